// File: rtl/lb_window3_if.sv
// Pixel-beat / column bus for lb_window3.
//   master : address generator side, drives beats and receives columns
//   slave  : line buffer side, accepts beats and drives columns
// Beat:   vaild, din, addr, sel
// Column: col_valid, col_top, col_mid, col_bot, col_addr, col_sel
interface lb_window3_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              vaild;
   logic [DATA_W-1:0] din;
   logic [ADDR_W-1:0] addr;
   logic              sel;

   logic              col_valid;
   logic [DATA_W-1:0] col_top;
   logic [DATA_W-1:0] col_mid;
   logic [DATA_W-1:0] col_bot;
   logic [ADDR_W-1:0] col_addr;
   logic              col_sel;

   modport master (
      output vaild, din, addr, sel,
      input  col_valid, col_top, col_mid, col_bot, col_addr, col_sel
   );

   modport slave (
      input  vaild, din, addr, sel,
      output col_valid, col_top, col_mid, col_bot, col_addr, col_sel
   );
endinterface

// File: rtl/lb_window3.sv
// Three-line circular line buffer. Stores the pixel stream in three line
// banks and emits a vertical column (rows r-2, r-1, r) one cycle after each
// accepted beat, once two full lines have been stored.
//
// Ports:
//   fclk        clock
//   reset       synchronous reset, active-low
//   frame_start one-cycle pulse, restarts the fill sequence
//   line_last   column address of the last pixel in a line
//   bus         lb_window3_if.slave (beat in, column out)
//   row_cnt     lines emitted since frame_start, saturating at 1023
//   state       fill state (encoding below)
//
// Build option: define LB_ZERO_PAD_EN to also emit columns during the fill
// lines, with the not-yet-stored rows forced to zero.
//
// state | meaning
// IDLE  | waiting for frame_start, beats ignored
// FILL0 | writing first line of the frame
// FILL1 | writing second line of the frame
// RUN   | two lines stored, columns emitted per beat
module lb_window3 #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              fclk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic [ADDR_W-1:0] line_last,
   lb_window3_if.slave       bus,
   output logic [9:0]        row_cnt,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL0 = 2'd1,
      FILL1 = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t st, st_nxt;
   logic [1:0] wb;

   logic [DATA_W-1:0] mem0 [0:DEPTH-1];
   logic [DATA_W-1:0] mem1 [0:DEPTH-1];
   logic [DATA_W-1:0] mem2 [0:DEPTH-1];

   logic accept, eol, emit, count_en;

   // A beat coinciding with frame_start belongs to the aborted frame.
   assign accept = bus.vaild && (st != IDLE) && !frame_start;
   assign eol    = accept && (bus.addr == line_last);

`ifdef LB_ZERO_PAD_EN
   assign emit     = accept;
   assign count_en = 1'b1;
`else
   assign emit     = accept && (st == RUN);
   assign count_en = (st == RUN);
`endif

   assign state = st;

   always_comb begin
      st_nxt = st;
      if (frame_start) begin
         st_nxt = FILL0;
      end else if (eol) begin
         case (st)
            FILL0:   st_nxt = FILL1;
            FILL1:   st_nxt = RUN;
            default: st_nxt = st;
         endcase
      end
   end

   always_ff @(posedge fclk) begin
      if (!reset) begin
         st      <= IDLE;
         wb      <= 2'd0;
         row_cnt <= 10'd0;
      end else begin
         st <= st_nxt;
         if (frame_start) begin
            wb      <= 2'd0;
            row_cnt <= 10'd0;
         end else if (eol) begin
            wb <= (wb == 2'd2) ? 2'd0 : wb + 2'd1;
            if (count_en && (row_cnt != 10'd1023))
               row_cnt <= row_cnt + 10'd1;
         end
      end
   end

   // Line memories: contents survive reset.
   always_ff @(posedge fclk) begin
      if (reset && accept) begin
         case (wb)
            2'd1:    mem1[bus.addr] <= bus.din;
            2'd2:    mem2[bus.addr] <= bus.din;
            default: mem0[bus.addr] <= bus.din;
         endcase
      end
   end

   // Registered reads: top from bank wb+1 (oldest line), mid from bank wb+2.
   // Neither is the bank being written this cycle.
   always_ff @(posedge fclk) begin
      if (!reset) begin
         bus.col_valid <= 1'b0;
         bus.col_top   <= '0;
         bus.col_mid   <= '0;
         bus.col_bot   <= '0;
         bus.col_addr  <= '0;
         bus.col_sel   <= 1'b0;
      end else begin
         bus.col_valid <= emit;
         if (emit) begin
            bus.col_bot  <= bus.din;
            bus.col_addr <= bus.addr;
            bus.col_sel  <= bus.sel;
            case (wb)
               2'd1: begin
                  bus.col_top <= mem2[bus.addr];
                  bus.col_mid <= mem0[bus.addr];
               end
               2'd2: begin
                  bus.col_top <= mem0[bus.addr];
                  bus.col_mid <= mem1[bus.addr];
               end
               default: begin
                  bus.col_top <= mem1[bus.addr];
                  bus.col_mid <= mem2[bus.addr];
               end
            endcase
`ifdef LB_ZERO_PAD_EN
            // Rows above the frame are padded with zero.
            if (st != RUN)
               bus.col_top <= '0;
            if (st == FILL0)
               bus.col_mid <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_lb_window3.sv
module tb_lb_window3;

`ifdef LB_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic       fclk;
   logic       reset;
   logic       frame_start;
   logic [9:0] line_last;
   logic [9:0] row_cnt;
   logic [1:0] state;

   int n_chk;
   int n_err;
   logic [7:0] hold_bot;

   lb_window3_if #(.DATA_W(8), .ADDR_W(10)) bus ();

   lb_window3 #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024)) dut (
      .fclk        (fclk),
      .reset       (reset),
      .frame_start (frame_start),
      .line_last   (line_last),
      .bus         (bus.slave),
      .row_cnt     (row_cnt),
      .state       (state)
   );

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle at the falling edge; return 1 time unit after the
   // following rising edge so the caller sees that edge's results.
   task automatic step(input bit fs, input bit v, input logic [9:0] a,
                       input logic [7:0] d, input bit s);
      @(negedge fclk);
      frame_start = fs;
      bus.vaild   = v;
      bus.addr    = a;
      bus.din     = d;
      bus.sel     = s;
      @(posedge fclk);
      #1;
   endtask

   function automatic logic [7:0] pix(input int r, input int c);
      return 8'(16 * r + c);
   endfunction

   function automatic logic [1:0] line_state(input int r);
      if (r == 0) return 2'd1;
      if (r == 1) return 2'd2;
      return 2'd3;
   endfunction

   function automatic logic [9:0] rows_after(input int r);
      if (PAD) return 10'(r + 1);
      if (r >= 2) return 10'(r - 1);
      return 10'd0;
   endfunction

   // One line of four pixels with line_last = 3; frame-relative row r.
   task automatic run_line(input int r, input bit gaps);
      bit exp_v;
      for (int c = 0; c < 4; c++) begin
         if (gaps) begin
            int k = int'($urandom_range(1, 3));
            for (int g = 0; g < k; g++) begin
               step(1'b0, 1'b0, 10'(c), 8'($urandom_range(0, 255)), 1'b1);
               chk("gap_valid", 32'(bus.col_valid), 32'd0);
               chk("gap_state", 32'(state), 32'(line_state(r)));
               chk("gap_hold", 32'(bus.col_bot), 32'(hold_bot));
            end
         end
         step(1'b0, 1'b1, 10'(c), pix(r, c), 1'(c & 1));
         exp_v = PAD || (r >= 2);
         chk("valid", 32'(bus.col_valid), 32'(exp_v));
         if (exp_v) begin
            hold_bot = pix(r, c);
            chk("top", 32'(bus.col_top), (r >= 2) ? 32'(pix(r - 2, c)) : 32'd0);
            chk("mid", 32'(bus.col_mid), (r >= 1) ? 32'(pix(r - 1, c)) : 32'd0);
            chk("bot", 32'(bus.col_bot), 32'(pix(r, c)));
            chk("caddr", 32'(bus.col_addr), 32'(c));
            chk("csel", 32'(bus.col_sel), 32'(c & 1));
         end
         chk("state", 32'(state), 32'(line_state((c == 3) ? r + 1 : r)));
      end
      chk("row_cnt", 32'(row_cnt), 32'(rows_after(r)));
   endtask

   task automatic start_frame();
      step(1'b1, 1'b0, 10'd0, 8'd0, 1'b0);
      chk("fs_state", 32'(state), 32'd1);
      chk("fs_rows", 32'(row_cnt), 32'd0);
      chk("fs_valid", 32'(bus.col_valid), 32'd0);
   endtask

   task automatic chk_all_zero();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_valid", 32'(bus.col_valid), 32'd0);
      chk("rst_top", 32'(bus.col_top), 32'd0);
      chk("rst_mid", 32'(bus.col_mid), 32'd0);
      chk("rst_bot", 32'(bus.col_bot), 32'd0);
      chk("rst_addr", 32'(bus.col_addr), 32'd0);
      chk("rst_sel", 32'(bus.col_sel), 32'd0);
      chk("rst_rows", 32'(row_cnt), 32'd0);
   endtask

   initial begin
      n_chk       = 0;
      n_err       = 0;
      hold_bot    = 8'd0;
      reset       = 1'b0;
      frame_start = 1'b0;
      line_last   = 10'd3;
      bus.vaild   = 1'b0;
      bus.din     = 8'd0;
      bus.addr    = 10'd0;
      bus.sel     = 1'b0;

      // Reset, then beats before any frame_start are ignored.
      step(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
      step(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
      chk_all_zero();
      @(negedge fclk);
      reset = 1'b1;
      step(1'b0, 1'b1, 10'd3, 8'hAA, 1'b1);
      chk("idle_valid", 32'(bus.col_valid), 32'd0);
      chk("idle_state", 32'(state), 32'd0);

      // Basic frame.
      start_frame();
      for (int r = 0; r < 4; r++) run_line(r, 1'b0);

      // Alignment of a single beat, then a bubble.
      step(1'b0, 1'b1, 10'd1, 8'h55, 1'b1);
      chk("lat_valid", 32'(bus.col_valid), 32'd1);
      chk("lat_top", 32'(bus.col_top), 32'h21);
      chk("lat_mid", 32'(bus.col_mid), 32'h31);
      chk("lat_bot", 32'(bus.col_bot), 32'h55);
      chk("lat_addr", 32'(bus.col_addr), 32'd1);
      chk("lat_sel", 32'(bus.col_sel), 32'd1);
      step(1'b0, 1'b0, 10'd2, 8'h77, 1'b0);
      chk("lat_off", 32'(bus.col_valid), 32'd0);
      chk("lat_hold", 32'(bus.col_bot), 32'h55);
      // Address beyond line_last: stored and emitted, no end of line.
      step(1'b0, 1'b1, 10'd5, 8'h66, 1'b0);
      chk("ovr_valid", 32'(bus.col_valid), 32'd1);
      chk("ovr_addr", 32'(bus.col_addr), 32'd5);
      chk("ovr_bot", 32'(bus.col_bot), 32'h66);
      chk("ovr_state", 32'(state), 32'd3);
      chk("ovr_rows", 32'(row_cnt), 32'(rows_after(3)));
      hold_bot = 8'h66;

      // Same frame with bubbles between beats.
      start_frame();
      for (int r = 0; r < 4; r++) run_line(r, 1'b1);

      // Restart mid-line; the beat in the frame_start cycle is ignored.
      step(1'b0, 1'b1, 10'd0, pix(4, 0), 1'b0);
      step(1'b0, 1'b1, 10'd1, pix(4, 1), 1'b1);
      hold_bot = pix(4, 1);
      step(1'b1, 1'b1, 10'd2, 8'hEE, 1'b0);
      chk("rs_state", 32'(state), 32'd1);
      chk("rs_rows", 32'(row_cnt), 32'd0);
      chk("rs_valid", 32'(bus.col_valid), 32'd0);
      chk("rs_hold", 32'(bus.col_bot), 32'(hold_bot));
      for (int r = 0; r < 4; r++) run_line(r, 1'b0);

      // One-cycle reset while running.
      step(1'b0, 1'b1, 10'd0, pix(4, 0), 1'b0);
      @(negedge fclk);
      reset     = 1'b0;
      bus.vaild = 1'b0;
      @(posedge fclk);
      #1;
      chk_all_zero();
      @(negedge fclk);
      reset = 1'b1;
      hold_bot = 8'd0;
      step(1'b0, 1'b1, 10'd3, 8'h99, 1'b1);
      chk("pr_valid", 32'(bus.col_valid), 32'd0);
      chk("pr_state", 32'(state), 32'd0);
      chk("pr_bot", 32'(bus.col_bot), 32'd0);
      start_frame();
      for (int r = 0; r < 4; r++) run_line(r, 1'b0);

      // row_cnt saturation: every beat is an end of line.
      line_last = 10'd0;
      start_frame();
      for (int i = 1; i <= 1030; i++) begin
         step(1'b0, 1'b1, 10'd0, 8'(i), 1'b0);
         if (i == 1024) chk("sat_1024", 32'(row_cnt), PAD ? 32'd1023 : 32'd1022);
      end
      chk("sat_end", 32'(row_cnt), 32'd1023);
      chk("sat_state", 32'(state), 32'd3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/lb_window3.md
Name: lb_window3

Overview:
- Three-line circular line buffer that sits directly downstream of the line-buffer address generator.
- Accepts one pixel per valid beat together with the generator's column address and lane tag.
- Stores the pixel stream and emits a vertical 3-pixel column (rows r-2, r-1, r) per beat to the 3x3 conv window/PE array.
- Tracks the fill state of the line memories per frame.

Parameters:
DATA_W, 8, pixel width in bits
ADDR_W, 10, column address width (matches address generator output)
DEPTH, 1024, words per line memory; must be >= line_last+1

Ports:
fclk  in  1  clock
reset  in  1  synchronous reset, active-low (reset==0 resets on rising fclk)
frame_start  in  1  one-cycle pulse: new frame begins; restarts fill
vaild  in  1  pixel beat valid
din  in  DATA_W  pixel data
addr  in  ADDR_W  column address of din
sel  in  1  lane tag from address generator; passed through
line_last  in  ADDR_W  column address of last pixel in a line; static within a frame
col_valid  out  1  column outputs valid
col_top  out  DATA_W  pixel at (r-2, addr)
col_mid  out  DATA_W  pixel at (r-1, addr)
col_bot  out  DATA_W  pixel at (r, addr)
col_addr  out  ADDR_W  addr delayed to align with column
col_sel  out  1  sel delayed to align with column
row_cnt  out  10  lines emitted in RUN since frame_start, saturating at 1023
state  out  2  IDLE=0, FILL0=1, FILL1=2, RUN=3

Behaviour:
- Reset (reset==0 at fclk edge): state=IDLE, bank pointer wb=0, all outputs 0. Memory contents are not cleared.
- Memories: three DEPTH x DATA_W banks B0..B2.
  - Synchronous write; synchronous read with a 1-cycle registered output.
- Write: when vaild==1 and state!=IDLE, write din to B[wb][addr].
- Read on the same beat:
  - mid = B[(wb+2)%3][addr]
  - top = B[(wb+1)%3][addr]
  - bot = din, registered.
- Never read and write the same bank in one cycle.
- Latency: col_* are valid exactly 1 cycle after the accepted beat. col_addr and col_sel are registered copies.
- End of line (EOL): vaild==1 and addr==line_last. On EOL, wb <= (wb+1)%3 after the write.
- FSM:
  - IDLE -> FILL0 on frame_start.
  - FILL0 -> FILL1 on EOL.
  - FILL1 -> RUN on EOL.
  - RUN stays in RUN on EOL and increments row_cnt.
- frame_start in any state, including mid-line: next state=FILL0, wb=0, row_cnt=0, col_valid=0 next cycle. Any beat in that same cycle is ignored.
- col_valid: 1 cycle after a beat accepted in RUN; otherwise 0.
  - Data outputs hold their last value when col_valid=0.
- vaild gaps: no state change. The pipeline does not advance and columns are emitted only for accepted beats.
- addr > line_last: the beat is written and, in RUN, emitted. No EOL.
- line_last changes mid-frame: undefined.
- row_cnt saturates at 1023 and does not wrap.

Optional Feature:
Macro LB_ZERO_PAD_EN.
- Defined:
  - Columns are also emitted in FILL0 and FILL1.
  - FILL0: col_top=0, col_mid=0.
  - FILL1: col_top=0, col_mid=stored line.
  - col_valid follows every accepted beat after frame_start.
  - row_cnt counts EOLs from FILL0 onward.
- Undefined: behaviour as above; no output before RUN.

Test Plan:
1. Basic: reset, frame_start, line_last=3, pixels p(r,c)=16r+c for r=0..3. Required: no col_valid during r=0,1. For r=2, col (top,mid,bot) = (0x0c,0x1c,0x2c) at c=c0 form (c, 16+c, 32+c), i.e. (0x02,0x12,0x22) at c=2. For r=3, (0x13,0x23,0x33) at c=3. row_cnt=2 at end.
2. Latency/alignment: in RUN, drive a beat with addr=1, sel=1. Required: col_valid=1, col_addr=1, col_sel=1 exactly one cycle later, and 0 the cycle after if vaild=0.
3. Gaps: insert random 1-3 cycle vaild=0 bubbles in test 1. Required: identical column sequence, and the state only changes on EOL beats.
4. Restart mid-line: in RUN at c=2, pulse frame_start. Required: state=FILL0, wb=0, row_cnt=0. The next two lines produce no col_valid; the third reproduces test 1 values.
5. Reset mid-operation: reset=0 for one cycle while in RUN. Required: state=IDLE, all outputs 0. Beats are ignored until frame_start.
6. LB_ZERO_PAD_EN build, test 1 stimulus. Required: r=0,c=1 gives (0,0,0x01); r=1,c=1 gives (0,0x01,0x11); r=2 as in test 1; row_cnt=4 after r=3.
